// File: rtl/ln_stream_controller.sv
// rtl/ln_stream_controller.sv - word-stream front end that feeds a LayerNorm core one vector at a time
// Loads vector n+1 while vector n's result drains; a watchdog aborts the job if the core hangs.
module ln_stream_controller #(
  parameter int D_MODEL        = 64,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_VECTORS    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_processing,
  output logic                          busy,
  output logic                          processing_done,
  output logic                          error,
  output logic [7:0]                    vec_count,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          core_start,
  output logic [D_MODEL*DATA_WIDTH-1:0] core_x,
  input  logic                          core_done,
  input  logic [D_MODEL*DATA_WIDTH-1:0] core_y
);
  localparam int CW = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int VW = D_MODEL * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_WORD = CW'(D_MODEL - 1);
  localparam logic [7:0]    NV        = 8'(NUM_VECTORS);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d;
  logic            in_full_q, in_full_d, core_busy_q, core_busy_d;
  logic            out_full_q, out_full_d, error_q, error_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [7:0]      loaded_q, loaded_d, vec_count_q, vec_count_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [VW-1:0]   in_buf_q, in_buf_d, out_buf_q, out_buf_d;
  logic            active, in_hs, out_hs, launch, capture, timeout;

  assign active          = (state_q == S_ACTIVE);
  assign busy            = active;
  assign processing_done = (state_q == S_DONE);
  assign error           = error_q;
  assign vec_count       = vec_count_q;
  assign in_ready        = active & ~in_full_q & (loaded_q < NV);
  assign out_valid       = active & out_full_q;
  assign out_data        = out_buf_q[int'(out_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
  assign core_x          = in_buf_q;
  assign in_hs           = in_valid & in_ready;
  assign out_hs          = out_valid & out_ready;
  // out_full blocks launch so a result can never overwrite one still draining
  assign launch          = active & in_full_q & ~core_busy_q & ~out_full_q;
  assign core_start      = launch;
  assign capture         = active & core_busy_q & core_done;
  assign timeout         = active & core_busy_q & ~core_done & (wd_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    in_full_d   = in_full_q;
    core_busy_d = core_busy_q;
    out_full_d  = out_full_q;
    error_d     = error_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    loaded_d    = loaded_q;
    vec_count_d = vec_count_q;
    wd_d        = wd_q;
    in_buf_d    = in_buf_q;
    out_buf_d   = out_buf_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_processing) begin
          state_d     = S_ACTIVE;
          error_d     = 1'b0;
          vec_count_d = '0;
          in_full_d   = 1'b0;
          core_busy_d = 1'b0;
          out_full_d  = 1'b0;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          loaded_d    = '0;
          wd_d        = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (in_hs) begin
          in_buf_d[int'(in_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = in_data;
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q == LAST_WORD) begin
            in_cnt_d  = '0;
            in_full_d = 1'b1;
            loaded_d  = loaded_q + 8'd1;
          end
        end
        if (out_hs) begin
          out_cnt_d = out_cnt_q + CW'(1);
          if (out_cnt_q == LAST_WORD) begin
            out_cnt_d   = '0;
            out_full_d  = 1'b0;
            vec_count_d = vec_count_q + 8'd1;
          end
        end
        if (launch) begin
          core_busy_d = 1'b1;
          wd_d        = WW'(1);
        end else if (capture) begin
          out_buf_d   = core_y;
          out_full_d  = 1'b1;
          in_full_d   = 1'b0;
          core_busy_d = 1'b0;
          wd_d        = '0;
        end else if (core_busy_q) begin
          wd_d = wd_q + WW'(1);
        end
        if (timeout) begin
          state_d     = S_ERR;
          error_d     = 1'b1;
          in_full_d   = 1'b0;
          core_busy_d = 1'b0;
          out_full_d  = 1'b0;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          loaded_d    = '0;
          wd_d        = '0;
        end else if (vec_count_d == NV) begin
          state_d = S_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_full_q   <= 1'b0;
      core_busy_q <= 1'b0;
      out_full_q  <= 1'b0;
      error_q     <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      loaded_q    <= '0;
      vec_count_q <= '0;
      wd_q        <= '0;
      in_buf_q    <= '0;
      out_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_full_q   <= in_full_d;
      core_busy_q <= core_busy_d;
      out_full_q  <= out_full_d;
      error_q     <= error_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      loaded_q    <= loaded_d;
      vec_count_q <= vec_count_d;
      wd_q        <= wd_d;
      in_buf_q    <= in_buf_d;
      out_buf_q   <= out_buf_d;
    end
  end
endmodule

// File: tb/tb_ln_stream_controller.sv
// tb/tb_ln_stream_controller.sv - randomized bench with an occupancy-level model of the stream controller
// Core stand-in returns y = x + 1 five cycles after core_start unless told to hang.
module tb_ln_stream_controller;
  localparam int D  = 4;
  localparam int DW = 16;
  localparam int NV = 2;
  localparam int TO = 16;
  localparam int VW = D * DW;

  logic clk = 1'b0, rst_n = 1'b1, start_processing = 1'b0;
  logic busy, processing_done, error;
  logic [7:0] vec_count;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic core_start, core_done;
  logic [VW-1:0] core_x;
  logic [VW-1:0] core_y = '0;
  logic model_done = 1'b0, spur_done = 1'b0, core_hang = 1'b0;

  assign core_done = model_done | spur_done;

  ln_stream_controller #(.D_MODEL(D), .DATA_WIDTH(DW), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_processing(start_processing), .busy(busy),
    .processing_done(processing_done), .error(error), .vec_count(vec_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_start(core_start), .core_x(core_x), .core_done(core_done), .core_y(core_y)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_state = 0, A = 0, O = 0, L = 0, Cv = 0, wd = 0, m_vec = 0;
  bit m_err = 0, act, e_in_ready, e_out_valid, e_start, cap;
  logic [DW-1:0] in_words [NV*D];
  logic [DW-1:0] e_data;
  logic [VW-1:0] e_x, xseen = '0;
  bit hs_in = 0, hs_out = 0, start_seen = 0, err_prev = 0;
  int cyc = 0, cyc_start = 0, cyc_err = 0, n_starts = 0, n_done = 0, n_in = 0;
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] feed_q[$];
  int out_mode = 0, vrate = 100;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle compare against the occupancy model; model advances on the model's own handshakes
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs", {busy, processing_done, error, in_ready, out_valid, core_start, vec_count, out_data}, 0);
        chk("reset_core_x", core_x, 0);
        m_state = 0; A = 0; O = 0; L = 0; Cv = 0; wd = 0; m_vec = 0; m_err = 0;
        hs_in = 0; hs_out = 0; start_seen = 0; err_prev = 0;
      end else begin
        act         = (m_state == 1);
        e_in_ready  = act && (A - Cv * D < D) && (A < NV * D);
        e_out_valid = act && (Cv * D > O);
        e_start     = act && (A >= (L + 1) * D) && (L == Cv) && (Cv * D == O);
        chk("busy", busy, act);
        chk("in_ready", in_ready, e_in_ready);
        chk("out_valid", out_valid, e_out_valid);
        chk("core_start", core_start, e_start);
        chk("processing_done", processing_done, m_state == 2);
        chk("error", error, m_err);
        chk("vec_count", vec_count, m_vec);
        if (e_out_valid) begin
          e_data = in_words[O] + 16'd1;
          chk("out_data", out_data, e_data);
        end
        if (e_start && core_start) begin
          for (int i = 0; i < D; i++) e_x[i*DW +: DW] = in_words[L*D + i];
          chk("core_x", core_x, e_x);
        end
        hs_in = in_valid & in_ready;
        hs_out = out_valid & out_ready;
        start_seen = core_start;
        if (hs_in) n_in++;
        if (hs_out) out_log.push_back(out_data);
        if (core_start) begin xseen = core_x; cyc_start = cyc; n_starts++; end
        if (processing_done) n_done++;
        if (error && !err_prev) cyc_err = cyc;
        err_prev = error;
        case (m_state)
          0, 3: if (start_processing) begin
            A = 0; O = 0; L = 0; Cv = 0; wd = 0; m_vec = 0; m_err = 0; m_state = 1;
          end
          2: m_state = 0;
          default: begin
            cap = core_done && (L > Cv);
            if (e_in_ready && in_valid) begin in_words[A] = in_data; A++; end
            if (e_out_valid && out_ready) O++;
            if (e_start) begin L++; wd = 1; end
            else if (cap) begin Cv++; wd = 0; end
            else if (L > Cv) wd++;
            m_vec = O / D;
            if (O == NV * D) m_state = 2;
            else if (L > Cv && wd >= TO) begin m_state = 3; m_err = 1; end
          end
        endcase
      end
    end
  end

  // Core stand-in: done pulse in cycle S+5 for a core_start in cycle S
  initial begin
    int pend;
    pend = 0;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (!rst_n) pend = 0;
      else begin
        if (pend > 0) begin pend--; if (pend == 0) model_done = 1'b1; end
        if (start_seen && !core_hang) begin
          pend = 4;
          for (int i = 0; i < D; i++) core_y[i*DW +: DW] = xseen[i*DW +: DW] + 16'd1;
        end
      end
    end
  end

  // Source holds a word until accepted; sink follows out_mode
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hs_in && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() == 0) in_valid = 1'b0;
      else if (!in_valid || hs_in) begin
        in_valid = ($urandom_range(99) < vrate);
        in_data = feed_q[0];
      end
      case (out_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = ($urandom_range(1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic start_job();
    @(posedge clk); #1; start_processing = 1'b1;
    @(posedge clk); #1; start_processing = 1'b0;
  endtask

  task automatic feed_seq(input int first, input int cnt);
    for (int k = 0; k < cnt; k++) feed_q.push_back(DW'(first + k));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < budget) begin @(posedge clk); k++; end
    chk({name, "_done_seen"}, n_done != n0, 1);
  endtask

  task automatic chk_seq(input string name, input int base);
    chk({name, "_len"}, out_log.size(), NV * D);
    for (int k = 0; k < NV * D && k < out_log.size(); k++) chk(name, out_log[k], base + k);
  endtask

  initial begin
    int s0, d0, i0, k;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: words 1..8, sink always ready
    out_log.delete(); s0 = n_starts; d0 = n_done; out_mode = 0;
    start_job(); feed_seq(1, 8);
    wait_done("t1", 300);
    repeat (2) @(posedge clk); #1;
    chk_seq("t1_out", 2);
    chk("t1_starts", n_starts - s0, 2);
    chk("t1_done_pulses", n_done - d0, 1);
    chk("t1_vec_count", vec_count, 2);

    // 2: alternating sink
    out_log.delete(); out_mode = 1;
    start_job(); feed_seq(1, 8);
    wait_done("t2", 300);
    chk_seq("t2_out", 2);

    // 3: sink stalled after first result; second vector loads, no launch
    out_log.delete(); out_mode = 3; s0 = n_starts; i0 = n_in;
    start_job(); feed_seq(1, 8);
    repeat (60) @(posedge clk); #1;
    chk("t3_words_in", n_in - i0, 8);
    chk("t3_starts_stalled", n_starts - s0, 1);
    chk("t3_in_ready_low", in_ready, 0);
    out_mode = 0;
    wait_done("t3", 300);
    chk("t3_starts", n_starts - s0, 2);
    chk_seq("t3_out", 2);

    // 4: hung core -> timeout, then a fresh job
    core_hang = 1'b1; out_mode = 0;
    start_job(); feed_seq(1, 4);
    k = 0;
    while (!error && k < 200) begin @(posedge clk); k++; end
    @(posedge clk); #1;
    chk("t4_error", error, 1);
    chk("t4_busy", busy, 0);
    chk("t4_timeout_latency", cyc_err - cyc_start, TO);
    core_hang = 1'b0; out_log.delete();
    start_job(); feed_seq(1, 8);
    wait_done("t4_rerun", 300);
    chk("t4_error_cleared", error, 0);
    chk_seq("t4_out", 2);

    // 5a: reset mid-drain
    out_log.delete(); out_mode = 3; d0 = n_done;
    start_job(); feed_seq(5, 8);
    k = 0;
    while (!out_valid && k < 200) begin @(posedge clk); k++; end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_immediate", {busy, out_valid, in_ready, core_start, processing_done, error, vec_count, out_data}, 0);
    feed_q.delete(); in_valid = 1'b0; out_mode = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t5_no_done_after_reset", n_done - d0, 0);

    // 5b: spurious core_done in IDLE
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t5_spurious_out_valid", out_valid, 0);

    // 5c: start_processing while ACTIVE
    out_log.delete(); s0 = n_starts; d0 = n_done;
    start_job(); feed_seq(1, 8);
    repeat (6) @(posedge clk);
    start_job();
    wait_done("t5c", 300);
    chk_seq("t5c_out", 2);
    chk("t5c_starts", n_starts - s0, 2);
    chk("t5c_done_pulses", n_done - d0, 1);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      out_log.delete(); out_mode = 2; vrate = 30 + $urandom_range(70);
      start_job();
      for (int w = 0; w < NV * D; w++) feed_q.push_back(DW'($urandom));
      wait_done("rand", 600);
      chk("rand_len", out_log.size(), NV * D);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end
endmodule
